// File: rtl/sr_cmd_conditioner.sv
// Synchronise, debounce and edge-detect two raw set/clear requests into mutually
// exclusive one-cycle s/r pulses plus a shadow q. Define SR_COLL_CNT_EN to build the collision counter.

module sr_deb_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic rise
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic             deb_dly_q, deb_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level, so any return to agreement restarts the qualification window.
  always_comb begin
    sync1_d   = raw_in;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) deb_d = sync2_q;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rise = deb_q & ~deb_dly_q;
endmodule

module sr_cmd_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned PRIO            = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_in,
  input  logic       clr_in,
  output logic       s,
  output logic       r,
  output logic       q_track,
  output logic [7:0] coll_cnt
);
  localparam int unsigned CH_SET = 0;
  localparam int unsigned CH_CLR = 1;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      (DEBOUNCE_CYCLES - 1) >= (64'd1 << CNT_W) || PRIO > 2) begin : g_bad_param
    $error("sr_cmd_conditioner: illegal DEBOUNCE_CYCLES/CNT_W/PRIO");
  end

  logic [1:0] raw;
  logic [1:0] rise;

  assign raw[CH_SET] = set_in;
  assign raw[CH_CLR] = clr_in;

  for (genvar g = 0; g < 2; g++) begin : g_chan
    sr_deb_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .raw_in(raw[g]),
      .rise  (rise[g])
    );
  end

  logic set_rise, clr_rise;
  logic grant_set, grant_clr;
  logic s_q, s_d;
  logic r_q, r_d;
  logic q_track_q, q_track_d;

  assign set_rise = rise[CH_SET];
  assign clr_rise = rise[CH_CLR];

  // A rise "grants" unless the policy lets the other side win; on a collision
  // with PRIO=0 both grant and so both cancel each other.
  assign grant_set = set_rise & (PRIO != 2);
  assign grant_clr = clr_rise & (PRIO != 1);

  always_comb begin
    s_d       = set_rise & ~grant_clr;
    r_d       = clr_rise & ~grant_set;
    q_track_d = q_track_q;
    if (s_d)      q_track_d = 1'b1;
    else if (r_d) q_track_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      q_track_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      r_q       <= r_d;
      q_track_q <= q_track_d;
    end
  end

  assign s       = s_q;
  assign r       = r_q;
  assign q_track = q_track_q;

`ifdef SR_COLL_CNT_EN
  logic       coll;
  logic [7:0] coll_cnt_q, coll_cnt_d;

  assign coll = set_rise & clr_rise;

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (coll && coll_cnt_q != 8'hFF) coll_cnt_d = coll_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) coll_cnt_q <= 8'h00;
    else        coll_cnt_q <= coll_cnt_d;
  end

  assign coll_cnt = coll_cnt_q;
`else
  assign coll_cnt = 8'h00;
`endif
endmodule
